// File: rtl/abc2dq.sv
// abc2dq: Clarke (a,b,c -> alpha,beta) followed by Park (alpha,beta -> d,q)
// on sampled three-phase feedback. One signed multiplier is shared across the
// six products and sequenced by a small FSM. Throughput is one sample every
// 8 cycles.
//
// Ports:
//   aclk, resetn       clock, synchronous active-low reset
//   a, b, c            phase samples, signed
//   sin, cos           electrical-angle sine/cosine, signed Q1.(decimal)
//   valid_in, ready    sample handshake; accept on valid_in && ready
//   alpha, beta        Clarke outputs, signed, registered
//   d, q               Park outputs, signed, registered
//   valid_out          one-cycle pulse when alpha/beta/d/q are updated
module abc2dq #(
    parameter int unsigned inout_width         = 16,
    parameter int unsigned inout_decimal_width = 15
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic [inout_width-1:0] a,
    input  logic [inout_width-1:0] b,
    input  logic [inout_width-1:0] c,
    input  logic [inout_width-1:0] sin,
    input  logic [inout_width-1:0] cos,
    input  logic                   valid_in,
    output logic                   ready,
    output logic [inout_width-1:0] alpha,
    output logic [inout_width-1:0] beta,
    output logic [inout_width-1:0] d,
    output logic [inout_width-1:0] q,
    output logic                   valid_out
);

    // round(2^frac / sqrt(3)) using integer binary search on 3*k^2 <= 2^(2*frac)
    function automatic int unsigned round_inv_sqrt3(input int unsigned frac);
        longint unsigned target;
        longint unsigned lo;
        longint unsigned hi;
        longint unsigned mid;
        target = 64'd1 << (2 * frac);
        lo     = 64'd0;
        hi     = 64'd1 << frac;
        for (int i = 0; i < 40; i++) begin
            mid = (lo + hi + 64'd1) / 64'd2;
            if (lo < hi) begin
                if (64'd3 * mid * mid <= target) lo = mid;
                else                              hi = mid - 64'd1;
            end
        end
        // round half up: compare against (k + 0.5)^2 scaled by 4
        if (64'd3 * (64'd2 * lo + 64'd1) * (64'd2 * lo + 64'd1) <= 64'd4 * target)
            lo = lo + 64'd1;
        return 32'(lo);
    endfunction

    localparam int unsigned sum_w  = inout_width + 2;     // 2a-b-c
    localparam int unsigned diff_w = inout_width + 1;     // b-c
    localparam int unsigned prod_w = sum_w + inout_width; // multiplier output
    localparam int unsigned acc_w  = prod_w + 1;          // two-product accumulator

    localparam int unsigned k3_val  = 32'(((64'd1 << inout_decimal_width) + 64'd1) / 64'd3);
    localparam int unsigned ks3_val = round_inv_sqrt3(inout_decimal_width);

    localparam logic signed [inout_width-1:0] k3  = inout_width'(k3_val);
    localparam logic signed [inout_width-1:0] ks3 = inout_width'(ks3_val);

    localparam logic signed [inout_width-1:0] out_max = {1'b0, {(inout_width-1){1'b1}}};
    localparam logic signed [inout_width-1:0] out_min = {1'b1, {(inout_width-1){1'b0}}};
    localparam logic signed [acc_w-1:0] acc_max = {{(acc_w-inout_width+1){1'b0}}, {(inout_width-1){1'b1}}};
    localparam logic signed [acc_w-1:0] acc_min = {{(acc_w-inout_width+1){1'b1}}, {(inout_width-1){1'b0}}};

    typedef enum logic [2:0] {
        st_idle,
        st_mul_a,
        st_mul_b,
        st_mul_ac,
        st_mul_bs,
        st_mul_bc,
        st_mul_as,
        st_done
    } state_t;

    state_t state;

    logic signed [inout_width-1:0] a_r, b_r, c_r, sin_r, cos_r;
    logic signed [inout_width-1:0] alpha_int, beta_int;
    logic signed [acc_w-1:0]       acc_d, acc_q;

    logic signed [sum_w-1:0]       abc_sum;
    logic signed [diff_w-1:0]      bc_diff;
    logic signed [sum_w-1:0]       mul_x;
    logic signed [inout_width-1:0] mul_y;
    logic signed [prod_w-1:0]      prod;
    logic signed [acc_w-1:0]       prod_ext;

    // Floor-scale by 2^decimal and clamp to the output range
    function automatic logic signed [inout_width-1:0] scale_sat(input logic signed [acc_w-1:0] x);
        logic signed [acc_w-1:0] s;
        s = x >>> inout_decimal_width;
        if (s > acc_max)      return out_max;
        else if (s < acc_min) return out_min;
        else                  return s[inout_width-1:0];
    endfunction

    // Pre-multiply sums are wide enough that they never wrap
    assign abc_sum = (sum_w'(a_r) <<< 1) - sum_w'(b_r) - sum_w'(c_r);
    assign bc_diff = diff_w'(b_r) - diff_w'(c_r);

    // Operand select for the shared multiplier
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            st_mul_a:  begin mul_x = abc_sum;            mul_y = k3;    end
            st_mul_b:  begin mul_x = sum_w'(bc_diff);    mul_y = ks3;   end
            st_mul_ac: begin mul_x = sum_w'(alpha_int);  mul_y = cos_r; end
            st_mul_bs: begin mul_x = sum_w'(beta_int);   mul_y = sin_r; end
            st_mul_bc: begin mul_x = sum_w'(beta_int);   mul_y = cos_r; end
            st_mul_as: begin mul_x = sum_w'(alpha_int);  mul_y = sin_r; end
            default:   begin mul_x = '0;                 mul_y = '0;    end
        endcase
    end

    assign prod     = prod_w'(mul_x) * prod_w'(mul_y);
    assign prod_ext = acc_w'(prod);

    // Sequencer: one product per state, results published in st_done
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state     <= st_idle;
            ready     <= 1'b1;
            valid_out <= 1'b0;
            alpha     <= '0;
            beta      <= '0;
            d         <= '0;
            q         <= '0;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            sin_r     <= '0;
            cos_r     <= '0;
            alpha_int <= '0;
            beta_int  <= '0;
            acc_d     <= '0;
            acc_q     <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                st_idle: begin
                    if (valid_in) begin
                        a_r   <= a;
                        b_r   <= b;
                        c_r   <= c;
                        sin_r <= sin;
                        cos_r <= cos;
                        ready <= 1'b0;
                        state <= st_mul_a;
                    end
                end
                st_mul_a: begin
                    alpha_int <= scale_sat(prod_ext);
                    state     <= st_mul_b;
                end
                st_mul_b: begin
                    beta_int <= scale_sat(prod_ext);
                    state    <= st_mul_ac;
                end
                st_mul_ac: begin
                    acc_d <= prod_ext;
                    state <= st_mul_bs;
                end
                st_mul_bs: begin
                    acc_d <= acc_d + prod_ext;
                    state <= st_mul_bc;
                end
                st_mul_bc: begin
                    acc_q <= prod_ext;
                    state <= st_mul_as;
                end
                st_mul_as: begin
                    acc_q <= acc_q - prod_ext;
                    state <= st_done;
                end
                st_done: begin
                    alpha     <= alpha_int;
                    beta      <= beta_int;
                    d         <= scale_sat(acc_d);
                    q         <= scale_sat(acc_q);
                    valid_out <= 1'b1;
                    ready     <= 1'b1;
                    state     <= st_idle;
                end
                default: begin
                    ready <= 1'b1;
                    state <= st_idle;
                end
            endcase
        end
    end

endmodule
